hls_result_reporter: RTL
========================

# hls_result_reporter

Return-path companion to the UART-triggered HLS start logic: watches the one-cycle `hls_start` pulse sent to the HLS accelerator and its `hls_finish` completion, and measures the run length in clock cycles. It latches the accelerator's return value and frames status, cycle count and result into a fixed-length byte packet. The packet goes out on a valid/ready byte stream to the UART transmitter, so the host learns that the accelerator has finished and gets its result.

## Interface
Parameters:
- `DATA_BYTES`, 4: width of `hls_return_val` in bytes (1..8).
- `TIMEOUT_CYCLES`, 16777216: RUN cycles without `hls_finish` before a timeout is reported; 0 disables the timeout.

Ports:
- `clk` in 1: single clock. One clock; reset is synchronous and active-high.
- `reset` in 1: synchronous, active-high reset.
- `hls_start` in 1: one-cycle start pulse, same signal that drives the accelerator.
- `hls_finish` in 1: accelerator completion pulse.
- `hls_return_val` in 8*DATA_BYTES: accelerator result; sampled only in the `hls_finish` cycle.
- `tx_data` out 8: packet byte to the UART transmitter.
- `tx_valid` out 1: `tx_data` is valid.
- `tx_ready` in 1: the transmitter accepts the byte when `tx_valid & tx_ready`.
- `busy` out 1: high when the state is not IDLE.

## Operation
- States are IDLE, RUN and SEND.
- **IDLE**
  - `hls_start` moves to RUN and clears `cyc_cnt` to 0.
  - `hls_finish` in IDLE is ignored.
- **RUN**
  - Every cycle: `cyc_cnt <= sat32(cyc_cnt+1)`, where `cyc_cnt` is 32-bit and saturates at 0xFFFFFFFF.
  - `hls_finish` does three things: latch `cnt_l = sat32(cyc_cnt+1)`, latch `res_l = hls_return_val`, and set `status = 0x01`. Then go to SEND.
  - Timeout: if `TIMEOUT_CYCLES != 0` and `cyc_cnt+1 == TIMEOUT_CYCLES` without `hls_finish`, set `cnt_l = TIMEOUT_CYCLES`, `res_l = 0`, `status = 0x02`, and go to SEND.
  - `hls_finish` and timeout in the same cycle: finish wins.
  - `hls_start` is ignored in RUN and SEND (no retrigger).
- **SEND**: emits N = 6 + DATA_BYTES bytes in this order:
  - 0xA5 header,
  - status,
  - `cnt_l` as 4 bytes, LSB first,
  - `res_l` as DATA_BYTES bytes, LSB first.
- The byte index advances on a `tx_valid & tx_ready` handshake. The handshake on byte N-1 returns the block to IDLE.
- `hls_finish` arriving during SEND is ignored.
- Cycle count meaning: number of RUN cycles including the finish cycle. A finish in the first cycle after start reports 1.

## Timing
- Reset values: state IDLE, `tx_valid` 0, `tx_data` 0x00, `busy` 0, `cyc_cnt` 0, `cnt_l` 0, `res_l` 0, status 0.
- Reset in RUN or SEND aborts immediately. No partial packet resumes afterwards; the next packet starts with 0xA5.
- `hls_start` in cycle t puts the block in RUN and raises `busy` from t+1.
- `hls_finish` in cycle t gives `tx_valid` = 1 with `tx_data` = 0xA5 in t+1.
- `tx_valid` stays high through SEND with no bubbles. With `tx_ready` held at 1, one byte is sent per cycle and the packet takes N cycles.
- While `tx_valid & !tx_ready`, `tx_data` and `tx_valid` hold stable.
- The final handshake in cycle t gives `tx_valid` = 0 and `busy` = 0 in t+1. An `hls_start` in t+1 is accepted.
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- Shared package `hls_report_pkg` holds:
  - `HDR_BYTE` = 8'hA5,
  - `ST_DONE` = 8'h01, `ST_TIMEOUT` = 8'h02,
  - the state enum {IDLE, RUN, SEND},
  - the `PKT_BYTES(DATA_BYTES)` length function.
- One sub-module is natural: `hls_byte_serializer`. It takes a parallel packet vector plus a load strobe and produces the valid/ready byte stream with a done pulse.
- The top level holds the FSM, the cycle counter and the timeout compare.

## Test plan
- DATA_BYTES=4: `hls_start`, then `hls_finish` 10 cycles later with `hls_return_val` = 0x12345678, `tx_ready` = 1 -> bytes A5 01 0A 00 00 00 78 56 34 12, then `busy` = 0.
- `hls_finish` in the first cycle after start -> count bytes 01 00 00 00. Toggling `tx_ready` randomly -> identical byte sequence, with `tx_data` stable during every stall.
- TIMEOUT_CYCLES=100 and no `hls_finish` -> A5 02 64 00 00 00 00 00 00 00.
- TIMEOUT_CYCLES=100 with `hls_finish` on RUN cycle 100 -> status 01, count 0x64, result latched.
- `hls_start` during RUN and during SEND, plus `hls_finish` in IDLE and SEND -> no effect, exactly one packet.
- `reset` asserted mid-SEND after 3 bytes -> outputs at reset values next cycle. A new start/finish then yields a full packet beginning with A5.

Source files
------------

// File: rtl/hls_report_pkg.sv
// hls_report_pkg: shared constants, state type and packet length for the HLS result reporter
package hls_report_pkg;

    localparam logic [7:0] HDR_BYTE   = 8'hA5;
    localparam logic [7:0] ST_DONE    = 8'h01;
    localparam logic [7:0] ST_TIMEOUT = 8'h02;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        SEND
    } state_t;

    // Header, status and 4 count bytes precede the result bytes
    function automatic int PKT_BYTES(input int data_bytes);
        return 6 + data_bytes;
    endfunction

endpackage

// File: rtl/hls_byte_serializer.sv
// hls_byte_serializer: streams a parallel packet as valid/ready bytes, byte 0 first
module hls_byte_serializer #(
    parameter int NBYTES = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [8*NBYTES-1:0] pkt,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic                done
);

    localparam int IW = $clog2(NBYTES + 1);

    logic [IW-1:0] idx;
    logic [IW-1:0] nxt_idx;
    logic          fire;
    logic          last;

    // Handshake decode; done marks the accepted final byte
    always_comb begin
        fire    = tx_valid & tx_ready;
        last    = idx == IW'(NBYTES - 1);
        nxt_idx = idx + IW'(1);
        done    = fire & last;
    end

    // Byte 0 is captured at load; later bytes come from pkt, which the owner holds stable while sending
    always_ff @(posedge clk) begin
        if (reset) begin
            idx      <= '0;
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
        end else if (load) begin
            idx      <= '0;
            tx_valid <= 1'b1;
            tx_data  <= pkt[7:0];
        end else if (fire) begin
            idx      <= last ? '0 : nxt_idx;
            tx_valid <= !last;
            tx_data  <= last ? 8'h00 : 8'(pkt >> {nxt_idx, 3'b000});
        end
    end

endmodule

// File: rtl/hls_result_reporter.sv
// hls_result_reporter: times an HLS run and reports status, cycle count and result as a byte packet
module hls_result_reporter
    import hls_report_pkg::*;
#(
    parameter int          DATA_BYTES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16777216
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    hls_start,
    input  logic                    hls_finish,
    input  logic [8*DATA_BYTES-1:0] hls_return_val,
    output logic [7:0]              tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic                    busy
);

    localparam int N  = PKT_BYTES(DATA_BYTES);
    localparam int RW = 8 * DATA_BYTES;

    state_t         state;
    logic [31:0]    cyc_cnt;
    logic [31:0]    cnt_inc;
    logic [31:0]    cnt_l;
    logic [RW-1:0]  res_l;
    logic [7:0]     status;
    logic           fin;
    logic           tmo;
    logic           load;
    logic           done;
    logic [8*N-1:0] pkt;

    // Saturating count, finish/timeout decode (finish wins) and packet assembly from latched fields
    always_comb begin
        cnt_inc = (&cyc_cnt) ? cyc_cnt : cyc_cnt + 32'd1;
        fin     = (state == RUN) && hls_finish;
        tmo     = (state == RUN) && !hls_finish && (TIMEOUT_CYCLES != 0)
                  && ({1'b0, cyc_cnt} + 33'd1 == 33'(TIMEOUT_CYCLES));
        load    = fin | tmo;
        pkt     = {res_l, cnt_l, status, HDR_BYTE};
    end

    // Control FSM: start opens RUN, finish or timeout latches the report, final handshake returns to IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            cyc_cnt <= '0;
            cnt_l   <= '0;
            res_l   <= '0;
            status  <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (hls_start) begin
                        state   <= RUN;
                        busy    <= 1'b1;
                        cyc_cnt <= '0;
                    end
                end
                RUN: begin
                    cyc_cnt <= cnt_inc;
                    if (fin) begin
                        state  <= SEND;
                        cnt_l  <= cnt_inc;
                        res_l  <= hls_return_val;
                        status <= ST_DONE;
                    end else if (tmo) begin
                        state  <= SEND;
                        cnt_l  <= 32'(TIMEOUT_CYCLES);
                        res_l  <= '0;
                        status <= ST_TIMEOUT;
                    end
                end
                SEND: begin
                    if (done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    hls_byte_serializer #(
        .NBYTES(N)
    ) u_ser (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .pkt     (pkt),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .done    (done)
    );

endmodule
